// File: rtl/bin_to_bcd_digits.sv
// bin_to_bcd_digits
// Sequential binary-to-BCD converter (shift-add-3 / double dabble), one
// input bit per clock. Feeds the 8-digit seven-segment scanner; display
// outputs are double-buffered and change only when a conversion completes.
//
// Build option: define BCD_LEADING_ZERO_BLANK_EN to blank leading zero
// digits through the enable mask (digit 0 always enabled). Undefined, all
// eight digits are always enabled.
//
// Ports:
//   clk     system clock, posedge
//   rst     synchronous active-high reset
//   value   unsigned binary operand, sampled on an accepted start
//   start   conversion request, accepted only while idle
//   busy    high from the cycle after an accepted start until done
//   done    one-cycle completion pulse, outputs update on the same edge
//   digits  BCD digits, digits[0] least significant (AN0)
//   en      per-digit enable mask, bit i gates digits[i]
//   ovf     last accepted value exceeded 99_999_999
//
// state  | meaning
// IDLE   | waiting for start, outputs hold last result
// SHIFT  | one add-3/shift step per clock, WIDTH steps total
// FINISH | publish digits/en/ovf, pulse done
module bin_to_bcd_digits #(
    parameter int WIDTH = 27
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      value,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [7:0][3:0]       digits,
    output logic [7:0]            en,
    output logic                  ovf
);

    localparam int CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] EN_RST = 8'h01;
`else
    localparam logic [7:0] EN_RST = 8'hff;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [31:0]      acc;
    logic [31:0]      acc_adj;
    logic [CNT_W-1:0] cnt;
    logic             ovf_pend;
    logic [7:0]       en_calc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_LAST) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state != IDLE);
    end

    // Add-3 correction ahead of each shift so every nibble stays a valid
    // BCD digit after doubling.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 8; i++) begin
            if (acc[i*4 +: 4] >= 4'd5) begin
                acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Enable mask for a normal (non-overflow) result.
    always_comb begin
        en_calc = 8'hff;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        begin
            logic lead;
            lead = 1'b0;
            for (int i = 7; i >= 1; i--) begin
                lead       = lead | (acc[i*4 +: 4] != 4'd0);
                en_calc[i] = lead;
            end
            en_calc[0] = 1'b1;
        end
`endif
    end

    // Datapath and double-buffered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            done     <= 1'b0;
            digits   <= '0;
            en       <= EN_RST;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= value;
                        acc      <= '0;
                        cnt      <= '0;
                        ovf_pend <= (32'(value) > 32'd99_999_999);
                    end
                end
                SHIFT: begin
                    acc   <= {acc_adj[30:0], shreg[WIDTH-1]};
                    shreg <= shreg << 1;
                    cnt   <= cnt + 1'b1;
                end
                FINISH: begin
                    done <= 1'b1;
                    if (ovf_pend) begin
                        // 4'hF is the scanner's blank code: all-dark display
                        digits <= '1;
                        en     <= 8'hff;
                        ovf    <= 1'b1;
                    end else begin
                        digits <= acc;
                        en     <= en_calc;
                        ovf    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
